// File: rtl/mano_pkg.sv
// Shared constants for the Mano basic computer: bus source codes, opcodes,
// register-reference / I/O bit positions, ALU functions and the strobe bundle.
package mano_pkg;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_NOP     = 3'd0,
    ALU_AND     = 3'd1,
    ALU_ADD     = 3'd2,
    ALU_PASS_DR = 3'd3
  } alu_op_e;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_LDA   = 3'd2;
  localparam logic [2:0] OP_STA   = 3'd3;
  localparam logic [2:0] OP_BUN   = 3'd4;
  localparam logic [2:0] OP_BSA   = 3'd5;
  localparam logic [2:0] OP_ISZ   = 3'd6;
  localparam logic [2:0] OP_RR_IO = 3'd7;

  localparam int RR_CLA = 11;
  localparam int RR_CLE = 10;
  localparam int RR_CMA = 9;
  localparam int RR_CME = 8;
  localparam int RR_CIR = 7;
  localparam int RR_CIL = 6;
  localparam int RR_INC = 5;
  localparam int RR_SPA = 4;
  localparam int RR_SNA = 3;
  localparam int RR_SZA = 2;
  localparam int RR_SZE = 1;
  localparam int RR_HLT = 0;

  localparam int IO_INP = 11;
  localparam int IO_OUT = 10;
  localparam int IO_SKI = 9;
  localparam int IO_SKO = 8;
  localparam int IO_ION = 7;
  localparam int IO_IOF = 6;

  typedef struct packed {
    logic ld_ar;
    logic ld_dr;
    logic ld_ac;
    logic ld_pc;
    logic ld_tr;
    logic inr_ar;
    logic inr_dr;
    logic inr_pc;
    logic clr_ar;
    logic clr_pc;
    logic mem_rd;
    logic mem_wr;
  } strobes_t;

endpackage

// File: rtl/mano_control_unit_seq_counter.sv
// Sequence counter T0..T7 with synchronous clear (priority) and increment.
module mano_seq_counter #(
  parameter int SC_W = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inr,
  input  logic            i_clr,
  output logic [SC_W-1:0] o_sc
);

  logic [SC_W-1:0] r_sc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_sc <= '0;
    else if (i_clr) r_sc <= '0;
    else if (i_inr) r_sc <= r_sc + SC_W'(1);
  end

  assign o_sc = r_sc;

endmodule

// File: rtl/mano_control_unit.sv
// Mano basic computer timing/control: sequence counter, instruction decode, per-cycle strobes.
// Optional interrupt cycle and I/O instructions enabled by defining MANO_INTERRUPT_EN.
module mano_control_unit
  import mano_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 12,
  parameter int SC_W   = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WORD_W-1:0] i_ir_in,
  input  logic              i_ac_zero,
  input  logic              i_ac_msb,
  input  logic              i_e_bit,
  input  logic              i_dr_zero,
`ifdef MANO_INTERRUPT_EN
  input  logic              i_fgi,
  input  logic              i_fgo,
  output logic              o_ien,
`endif
  output logic [SC_W-1:0]   o_sc,
  output logic [2:0]        o_bus_sel,
  output logic              o_ld_ar,
  output logic              o_ld_dr,
  output logic              o_ld_ac,
  output logic              o_ld_pc,
  output logic              o_ld_tr,
  output logic              o_inr_ar,
  output logic              o_inr_dr,
  output logic              o_inr_pc,
  output logic              o_clr_ar,
  output logic              o_clr_pc,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [2:0]        o_alu_op,
  output logic [ADDR_W-1:0] o_rr_op,
  output logic              o_halt
);

  localparam logic [SC_W-1:0] SC0 = SC_W'(0);
  localparam logic [SC_W-1:0] SC1 = SC_W'(1);
  localparam logic [SC_W-1:0] SC2 = SC_W'(2);
  localparam logic [SC_W-1:0] SC3 = SC_W'(3);
  localparam logic [SC_W-1:0] SC4 = SC_W'(4);
  localparam logic [SC_W-1:0] SC5 = SC_W'(5);
  localparam logic [SC_W-1:0] SC6 = SC_W'(6);

  logic [SC_W-1:0]   w_sc;
  logic [2:0]        w_opcode;
  logic [ADDR_W-1:0] w_addr;
  strobes_t          w_st;
  bus_sel_e          w_bus;
  alu_op_e           w_alu;
  logic [ADDR_W-1:0] w_rr;
  logic              w_clr_sc;
  logic              w_set_halt;
  logic              w_load_i;
  logic              r_i;
  logic              r_halt;
`ifdef MANO_INTERRUPT_EN
  logic              r_ien;
  logic              r_r;
  logic              w_ien_set;
  logic              w_ien_clr;
  logic              w_r_set;
  logic              w_r_clr;
`endif

  assign w_opcode = i_ir_in[WORD_W-2 -: 3];
  assign w_addr   = i_ir_in[ADDR_W-1:0];

  mano_seq_counter #(.SC_W(SC_W)) u_sc (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inr (!w_clr_sc),
    .i_clr (w_clr_sc),
    .o_sc  (w_sc)
  );

  always_comb begin
    // NOTE: every combinational output is defaulted first so no branch can infer a latch.
    w_st       = '0;
    w_bus      = BUS_NONE;
    w_alu      = ALU_NOP;
    w_rr       = '0;
    w_clr_sc   = 1'b0;
    w_set_halt = 1'b0;
    w_load_i   = 1'b0;
`ifdef MANO_INTERRUPT_EN
    w_ien_set  = 1'b0;
    w_ien_clr  = 1'b0;
    w_r_clr    = 1'b0;
`endif
    if (i_rst || r_halt) begin
      w_clr_sc = 1'b1;
    end
`ifdef MANO_INTERRUPT_EN
    else if (r_r) begin
      // Interrupt cycle: save PC at M[0], then branch to address 1.
      case (w_sc)
        SC0: begin w_st.clr_ar = 1'b1; w_bus = BUS_PC; w_st.ld_tr = 1'b1; end
        SC1: begin w_bus = BUS_TR; w_st.mem_wr = 1'b1; w_st.clr_pc = 1'b1; end
        SC2: begin w_st.inr_pc = 1'b1; w_ien_clr = 1'b1; w_r_clr = 1'b1; w_clr_sc = 1'b1; end
        default: w_clr_sc = 1'b1;
      endcase
    end
`endif
    else begin
      case (w_sc)
        SC0: begin w_bus = BUS_PC; w_st.ld_ar = 1'b1; end
        SC1: begin w_bus = BUS_MEM; w_st.mem_rd = 1'b1; w_st.inr_pc = 1'b1; end
        SC2: begin w_bus = BUS_IR; w_st.ld_ar = 1'b1; w_load_i = 1'b1; end
        SC3: begin
          if (w_opcode == OP_RR_IO) begin
            w_clr_sc = 1'b1;
            if (!r_i) begin
              w_rr         = w_addr;
              w_st.inr_pc  = (w_addr[RR_SPA] & ~i_ac_msb) | (w_addr[RR_SNA] & i_ac_msb) |
                             (w_addr[RR_SZA] & i_ac_zero) | (w_addr[RR_SZE] & ~i_e_bit);
              w_set_halt   = w_addr[RR_HLT];
            end
`ifdef MANO_INTERRUPT_EN
            else begin
              w_ien_set   = w_addr[IO_ION];
              w_ien_clr   = w_addr[IO_IOF];
              w_st.inr_pc = (w_addr[IO_SKI] & i_fgi) | (w_addr[IO_SKO] & i_fgo);
            end
`endif
          end else if (r_i) begin
            w_bus = BUS_MEM; w_st.mem_rd = 1'b1; w_st.ld_ar = 1'b1;
          end
        end
        SC4: begin
          case (w_opcode)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              w_bus = BUS_MEM; w_st.mem_rd = 1'b1; w_st.ld_dr = 1'b1;
            end
            OP_STA: begin w_bus = BUS_AC; w_st.mem_wr = 1'b1; w_clr_sc = 1'b1; end
            OP_BUN: begin w_bus = BUS_AR; w_st.ld_pc = 1'b1; w_clr_sc = 1'b1; end
            OP_BSA: begin w_bus = BUS_PC; w_st.mem_wr = 1'b1; w_st.inr_ar = 1'b1; end
            default: w_clr_sc = 1'b1;
          endcase
        end
        SC5: begin
          w_clr_sc = 1'b1;
          case (w_opcode)
            OP_AND: begin w_alu = ALU_AND;     w_st.ld_ac = 1'b1; end
            OP_ADD: begin w_alu = ALU_ADD;     w_st.ld_ac = 1'b1; end
            OP_LDA: begin w_alu = ALU_PASS_DR; w_st.ld_ac = 1'b1; end
            OP_BSA: begin w_bus = BUS_AR;      w_st.ld_pc = 1'b1; end
            OP_ISZ: begin w_st.inr_dr = 1'b1;  w_clr_sc = 1'b0;   end
            default: ;
          endcase
        end
        SC6: begin
          w_clr_sc = 1'b1;
          if (w_opcode == OP_ISZ) begin
            w_bus = BUS_DR; w_st.mem_wr = 1'b1; w_st.inr_pc = i_dr_zero;
          end
        end
        default: w_clr_sc = 1'b1;  // T7 is unreachable; recover to T0
      endcase
    end
  end

`ifdef MANO_INTERRUPT_EN
  assign w_r_set = !i_rst && !r_halt && (w_sc > SC2) && r_ien && (i_fgi || i_fgo);
  assign o_ien   = r_ien;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_i    <= 1'b0;
      r_halt <= 1'b0;
`ifdef MANO_INTERRUPT_EN
      r_ien  <= 1'b0;
      r_r    <= 1'b0;
`endif
    end else begin
      if (w_load_i)   r_i    <= i_ir_in[WORD_W-1];
      if (w_set_halt) r_halt <= 1'b1;
`ifdef MANO_INTERRUPT_EN
      if (w_ien_clr)      r_ien <= 1'b0;
      else if (w_ien_set) r_ien <= 1'b1;
      if (w_r_clr)        r_r   <= 1'b0;
      else if (w_r_set)   r_r   <= 1'b1;
`endif
    end
  end

  assign o_sc      = w_sc;
  assign o_bus_sel = w_bus;
  assign o_alu_op  = w_alu;
  assign o_rr_op   = w_rr;
  assign o_halt    = r_halt;
  assign o_ld_ar   = w_st.ld_ar;
  assign o_ld_dr   = w_st.ld_dr;
  assign o_ld_ac   = w_st.ld_ac;
  assign o_ld_pc   = w_st.ld_pc;
  assign o_ld_tr   = w_st.ld_tr;
  assign o_inr_ar  = w_st.inr_ar;
  assign o_inr_dr  = w_st.inr_dr;
  assign o_inr_pc  = w_st.inr_pc;
  assign o_clr_ar  = w_st.clr_ar;
  assign o_clr_pc  = w_st.clr_pc;
  assign o_mem_rd  = w_st.mem_rd;
  assign o_mem_wr  = w_st.mem_wr;

endmodule

// File: tb/tb_mano_control_unit.sv
// Directed bench for mano_control_unit: per-cycle expected outputs queued, then compared at negedge.
// Define MANO_INTERRUPT_EN to also exercise the interrupt cycle.
module tb_mano_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir_in = '0;
  logic        ac_zero = 1'b0, ac_msb = 1'b0, e_bit = 1'b0, dr_zero = 1'b0;
  logic [2:0]  sc, bus_sel, alu_op;
  logic        ld_ar, ld_dr, ld_ac, ld_pc, ld_tr;
  logic        inr_ar, inr_dr, inr_pc, clr_ar, clr_pc, mem_rd, mem_wr, halt;
  logic [11:0] rr_op;
`ifdef MANO_INTERRUPT_EN
  logic        fgi = 1'b0, fgo = 1'b0, ien;
`endif

  always #5 clk = ~clk;

  mano_control_unit dut (
    .i_clk(clk), .i_rst(rst), .i_ir_in(ir_in),
    .i_ac_zero(ac_zero), .i_ac_msb(ac_msb), .i_e_bit(e_bit), .i_dr_zero(dr_zero),
`ifdef MANO_INTERRUPT_EN
    .i_fgi(fgi), .i_fgo(fgo), .o_ien(ien),
`endif
    .o_sc(sc), .o_bus_sel(bus_sel),
    .o_ld_ar(ld_ar), .o_ld_dr(ld_dr), .o_ld_ac(ld_ac), .o_ld_pc(ld_pc), .o_ld_tr(ld_tr),
    .o_inr_ar(inr_ar), .o_inr_dr(inr_dr), .o_inr_pc(inr_pc),
    .o_clr_ar(clr_ar), .o_clr_pc(clr_pc),
    .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
    .o_alu_op(alu_op), .o_rr_op(rr_op), .o_halt(halt)
  );

  localparam logic [11:0] S_LD_AR  = 12'h800, S_LD_DR  = 12'h400, S_LD_AC  = 12'h200;
  localparam logic [11:0] S_LD_PC  = 12'h100, S_LD_TR  = 12'h080, S_INR_AR = 12'h040;
  localparam logic [11:0] S_INR_DR = 12'h020, S_INR_PC = 12'h010, S_CLR_AR = 12'h008;
  localparam logic [11:0] S_CLR_PC = 12'h004, S_MEM_RD = 12'h002, S_MEM_WR = 12'h001;

  typedef struct {
    string       tag;
    logic [33:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [33:0] mk(int s, int b, logic [11:0] st, int a, logic [11:0] rr, logic h);
    return {3'(s), 3'(b), st, 3'(a), rr, h};
  endfunction

  function automatic logic [33:0] observed();
    return {sc, bus_sel, ld_ar, ld_dr, ld_ac, ld_pc, ld_tr, inr_ar, inr_dr, inr_pc,
            clr_ar, clr_pc, mem_rd, mem_wr, alu_op, rr_op, halt};
  endfunction

  task automatic push(string tag, logic [33:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [33:0] got;
    while (q.size() > 0) begin
      @(negedge clk);
      e   = q.pop_front();
      got = observed();
      total++;
      assert (got === e.v) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, got, e.v);
      end
    end
  endtask

  // Starts an instruction at the beginning of a cycle (releasing reset if held).
  task automatic start(logic [15:0] ir);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ir_in = ir;
  endtask

  task automatic fetch(string n);
    push({n, "_T0"}, mk(0, 2, S_LD_AR, 0, 12'h000, 1'b0));
    push({n, "_T1"}, mk(1, 7, S_MEM_RD | S_INR_PC, 0, 12'h000, 1'b0));
    push({n, "_T2"}, mk(2, 5, S_LD_AR, 0, 12'h000, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    push("reset_state", mk(0, 0, 12'h000, 0, 12'h000, 1'b0));
    drain();

    start(16'h2005);  // LDA direct
    fetch("lda");
    push("lda_T3", mk(3, 0, 12'h000, 0, 12'h000, 1'b0));
    push("lda_T4", mk(4, 7, S_MEM_RD | S_LD_DR, 0, 12'h000, 1'b0));
    push("lda_T5", mk(5, 0, S_LD_AC, 3, 12'h000, 1'b0));
    drain();

    start(16'h8005);  // AND indirect
    fetch("and_i");
    push("and_i_T3", mk(3, 7, S_MEM_RD | S_LD_AR, 0, 12'h000, 1'b0));
    push("and_i_T4", mk(4, 7, S_MEM_RD | S_LD_DR, 0, 12'h000, 1'b0));
    push("and_i_T5", mk(5, 0, S_LD_AC, 1, 12'h000, 1'b0));
    drain();

    start(16'h1234);  // ADD direct
    fetch("add");
    push("add_T3", mk(3, 0, 12'h000, 0, 12'h000, 1'b0));
    push("add_T4", mk(4, 7, S_MEM_RD | S_LD_DR, 0, 12'h000, 1'b0));
    push("add_T5", mk(5, 0, S_LD_AC, 2, 12'h000, 1'b0));
    drain();

    start(16'h7004); ac_zero = 1'b1;  // SZA, skip taken
    fetch("sza1");
    push("sza1_T3", mk(3, 0, S_INR_PC, 0, 12'h004, 1'b0));
    drain();

    start(16'h7004); ac_zero = 1'b0;  // SZA, no skip
    fetch("sza0");
    push("sza0_T3", mk(3, 0, 12'h000, 0, 12'h004, 1'b0));
    drain();

    start(16'h7010); ac_msb = 1'b0;   // SPA on positive AC
    fetch("spa");
    push("spa_T3", mk(3, 0, S_INR_PC, 0, 12'h010, 1'b0));
    drain();

    start(16'h7008);                  // SNA on positive AC
    fetch("sna");
    push("sna_T3", mk(3, 0, 12'h000, 0, 12'h008, 1'b0));
    drain();

    start(16'h7002); e_bit = 1'b0;    // SZE with E clear
    fetch("sze");
    push("sze_T3", mk(3, 0, S_INR_PC, 0, 12'h002, 1'b0));
    drain();

    start(16'h3007);
    fetch("sta");
    push("sta_T3", mk(3, 0, 12'h000, 0, 12'h000, 1'b0));
    push("sta_T4", mk(4, 4, S_MEM_WR, 0, 12'h000, 1'b0));
    drain();

    start(16'h4100);
    fetch("bun");
    push("bun_T3", mk(3, 0, 12'h000, 0, 12'h000, 1'b0));
    push("bun_T4", mk(4, 1, S_LD_PC, 0, 12'h000, 1'b0));
    drain();

    start(16'h5100);
    fetch("bsa");
    push("bsa_T3", mk(3, 0, 12'h000, 0, 12'h000, 1'b0));
    push("bsa_T4", mk(4, 2, S_MEM_WR | S_INR_AR, 0, 12'h000, 1'b0));
    push("bsa_T5", mk(5, 1, S_LD_PC, 0, 12'h000, 1'b0));
    drain();

    start(16'h6010); dr_zero = 1'b1;  // ISZ, result zero
    fetch("isz1");
    push("isz1_T3", mk(3, 0, 12'h000, 0, 12'h000, 1'b0));
    push("isz1_T4", mk(4, 7, S_MEM_RD | S_LD_DR, 0, 12'h000, 1'b0));
    push("isz1_T5", mk(5, 0, S_INR_DR, 0, 12'h000, 1'b0));
    push("isz1_T6", mk(6, 3, S_MEM_WR | S_INR_PC, 0, 12'h000, 1'b0));
    drain();

    start(16'h6010); dr_zero = 1'b0;  // ISZ, result nonzero
    fetch("isz0");
    push("isz0_T3", mk(3, 0, 12'h000, 0, 12'h000, 1'b0));
    push("isz0_T4", mk(4, 7, S_MEM_RD | S_LD_DR, 0, 12'h000, 1'b0));
    push("isz0_T5", mk(5, 0, S_INR_DR, 0, 12'h000, 1'b0));
    push("isz0_T6", mk(6, 3, S_MEM_WR, 0, 12'h000, 1'b0));
    drain();

    start(16'hF080);  // I/O class (ION): no strobes at T3, SC back to 0
    fetch("io");
    push("io_T3", mk(3, 0, 12'h000, 0, 12'h000, 1'b0));
    drain();

`ifdef MANO_INTERRUPT_EN
    start(16'h7800); fgi = 1'b1;      // CLA with a pending input flag
    total++;
    assert (ien === 1'b1) else begin
      bad++;
      $error("FAIL ien_after_ion observed=%b expected=1", ien);
    end
    fetch("cla");
    push("cla_T3", mk(3, 0, 12'h000, 0, 12'h800, 1'b0));
    push("int_RT0", mk(0, 2, S_CLR_AR | S_LD_TR, 0, 12'h000, 1'b0));
    push("int_RT1", mk(1, 6, S_MEM_WR | S_CLR_PC, 0, 12'h000, 1'b0));
    push("int_RT2", mk(2, 0, S_INR_PC, 0, 12'h000, 1'b0));
    drain();

    start(16'h7800);
    fetch("post_int");
    push("post_int_T3", mk(3, 0, 12'h000, 0, 12'h800, 1'b0));
    drain();
    total++;
    assert (ien === 1'b0) else begin
      bad++;
      $error("FAIL ien_after_int observed=%b expected=0", ien);
    end
    fgi = 1'b0;
`endif

    start(16'h2005);  // LDA interrupted by reset during T4
    fetch("lda_rst");
    push("lda_rst_T3", mk(3, 0, 12'h000, 0, 12'h000, 1'b0));
    push("lda_rst_T4", mk(4, 7, S_MEM_RD | S_LD_DR, 0, 12'h000, 1'b0));
    drain();
    rst = 1'b1;
    push("rst_mid_T4", mk(0, 0, 12'h000, 0, 12'h000, 1'b0));
    drain();

    start(16'h7001);  // HLT
    fetch("hlt");
    push("hlt_T3", mk(3, 0, 12'h000, 0, 12'h001, 1'b0));
    for (int k = 0; k < 10; k++) push($sformatf("halt_hold%0d", k), mk(0, 0, 12'h000, 0, 12'h000, 1'b1));
    drain();

    rst = 1'b1;
    push("halt_cleared_by_rst", mk(0, 0, 12'h000, 0, 12'h000, 1'b0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
